// File: rtl/blink_monitor_pkg.sv
// Shared definitions for the blink monitor and its helpers.
// Holds the measurement FSM state encoding and the default counter width.
package blink_monitor_pkg;

  // Default width of the period and high-time counters.
  localparam int unsigned CNT_W_DEFAULT = 32;

  // Measurement FSM states.
  //   IDLE : disabled, counters held at zero
  //   ARM  : enabled, waiting for the first rising edge to start a period
  //   MEAS : counting; every rising edge closes one period and opens the next
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

endpackage : blink_monitor_pkg

// File: rtl/blink_monitor_edge_sync.sv
// Two-flop synchronizer plus one history flop with edge detection.
// level is the synchronized input. rise and fall are single-cycle strobes
// derived from the synchronized level and its one-cycle-old copy. Both edges
// see the same latency, so interval measurements built on them are unbiased.
module edge_sync (
  input  logic clk,
  input  logic rst,     // synchronous, active-low
  input  logic d_in,    // asynchronous input
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next-state for the synchronizer chain: each stage copies the previous one.
  always_comb begin
    meta_d = d_in;
    s1_d   = meta_q;
    s2_d   = s1_q;
  end

  // Synchronizer and history registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  // Edge strobes compare the synchronized level with its history copy.
  always_comb begin
    level = s1_q;
    rise  = s1_q & ~s2_q;
    fall  = ~s1_q & s2_q;
  end

endmodule : edge_sync

// File: rtl/blink_monitor.sv
// Blink monitor: measures the period (rise to rise) and the high time of an
// asynchronous toggling signal, in clk cycles, and presents each result on a
// valid/ready output with a sticky overrun flag and a timeout pulse.
//
// Result handshake (valid/ready):
//   A result transfers on any cycle where valid and ready are both 1. valid
//   then drops on the next cycle unless a new result loads on that same cycle,
//   in which case valid stays 1 with the new data. While valid=1 and ready=0
//   the data is held stable; a new result arriving then overwrites the held
//   data and sets overrun, which stays set until reset or en=0.
//
// state_dbg exposes the FSM state for observation; it has no functional role.
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             timeout,
  output state_e           state_dbg
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic sig_level, sig_rise, sig_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // cycles since the opening rise
  logic [CNT_W-1:0] hcnt_q, hcnt_d;      // high cycles since the opening rise
  logic             high_run_q, high_run_d; // still inside the high phase
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             load;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (sig_in),
    .level (sig_level),
    .rise  (sig_rise),
    .fall  (sig_fall)
  );

  // Next-state logic: FSM, counters, result register and status flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    high_run_d  = high_run_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    timeout_d   = 1'b0;
    load        = 1'b0;

    // A transfer retires the held result; a same-cycle load re-asserts below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d      = ZERO;
        hcnt_d     = ZERO;
        high_run_d = 1'b0;
        if (en) begin
          state_d = ARM;
        end
      end

      ARM: begin
        // Only a rise matters here; a fall just means we armed mid-pulse.
        if (sig_rise) begin
          cnt_d      = ONE;
          hcnt_d     = ONE;
          high_run_d = 1'b1;
          state_d    = MEAS;
        end
      end

      MEAS: begin
        if (sig_rise) begin
          // Close this period and open the next one without a gap. A rise
          // on the MAX_CNT cycle still produces a result.
          load       = 1'b1;
          cnt_d      = ONE;
          hcnt_d     = ONE;
          high_run_d = 1'b1;
        end else if (cnt_q == MAX_CNT) begin
          // Abandon the measurement rather than let the counter wrap.
          timeout_d  = 1'b1;
          cnt_d      = ZERO;
          hcnt_d     = ZERO;
          high_run_d = 1'b0;
          state_d    = ARM;
        end else begin
          cnt_d = cnt_q + ONE;
          // High time counts until the first fall, then freezes.
          if (sig_fall) begin
            high_run_d = 1'b0;
          end else if (high_run_q && sig_level) begin
            hcnt_d = hcnt_q + ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      period_d    = cnt_q;
      high_time_d = hcnt_q;
      valid_d     = 1'b1;
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end
    end

    // Disabling drops any partial measurement and clears result status.
    if (!en) begin
      state_d    = IDLE;
      cnt_d      = ZERO;
      hcnt_d     = ZERO;
      high_run_d = 1'b0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= ZERO;
      hcnt_q      <= ZERO;
      high_run_q  <= 1'b0;
      period_q    <= ZERO;
      high_time_q <= ZERO;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      high_run_q  <= high_run_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    period    = period_q;
    high_time = high_time_q;
    valid     = valid_q;
    overrun   = overrun_q;
    timeout   = timeout_q;
    state_dbg = state_q;
  end

endmodule : blink_monitor

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor with an 8-bit counter and MAX_CNT=50.
module tb_blink_monitor;
  import blink_monitor_pkg::*;

  localparam int CW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] period, high_time;
  logic          valid, overrun, timeout;
  state_e        state_dbg;

  always #5 clk = ~clk;

  blink_monitor #(.CNT_W(CW), .MAX_CNT(8'd50)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [2*CW-1:0] exp_q[$];
  logic [2*CW-1:0] got_q[$];
  int              vcnt = 0;   // cycles with valid=1
  int              tcnt = 0;   // timeout pulses seen
  int              ncyc = 0;

  function automatic logic [2*CW-1:0] pk(input int p, input int h);
    logic [31:0] pv, hv;
    pv = p;
    hv = h;
    return {pv[CW-1:0], hv[CW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample #1 after the rising edge and log what the DUT shows.
  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    if (valid && ready) got_q.push_back({period, high_time});
    if (valid) vcnt++;
    if (timeout) tcnt++;
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      repeat (hi) cyc();
      sig_in = 1'b0;
      repeat (per - hi) cyc();
    end
  endtask

  task automatic restart();
    en = 1'b0;
    ready = 1'b0;
    sig_in = 1'b0;
    repeat (3) cyc();
    got_q.delete();
    exp_q.delete();
    vcnt = 0;
    tcnt = 0;
    en = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic score(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk({tag, "_result"}, got_q[i], exp_q[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int meas_at, to_at;
    state_e to_state;

    // Reset state
    rst = 1'b0;
    repeat (2) cyc();
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    cyc();

    // Steady 10/4 square wave: one result per period after the first rise
    restart();
    chk("arm_state", 32'(state_dbg), 32'(ARM));
    ready = 1'b1;
    wave(10, 4, 5);
    repeat (4) exp_q.push_back(pk(10, 4));
    score("sq10");
    chk("sq10_valid_cycles", vcnt, 4);
    chk("sq10_timeouts", tcnt, 0);

    // Back-pressure across three rises
    restart();
    wave(10, 4, 1);
    wave(10, 6, 1);
    chk("bp_valid1", valid, 1);
    chk("bp_period1", period, 10);
    chk("bp_high1", high_time, 4);
    chk("bp_ovr1", overrun, 0);
    sig_in = 1'b1;
    repeat (2) cyc();
    chk("bp_stable_high", high_time, 4);
    repeat (3) cyc();
    chk("bp_valid2", valid, 1);
    chk("bp_period2", period, 10);
    chk("bp_high2", high_time, 6);
    chk("bp_ovr2", overrun, 1);
    sig_in = 1'b0;
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    chk("bp_xfer_valid", valid, 0);
    chk("bp_xfer_ovr", overrun, 1);
    repeat (5) cyc();
    chk("bp_ovr_sticky", overrun, 1);
    en = 1'b0;
    cyc();
    chk("bp_en0_ovr", overrun, 0);
    chk("bp_en0_valid", valid, 0);

    // Timeout after one rise with the input held low
    restart();
    meas_at = -1;
    to_at = -1;
    to_state = IDLE;
    sig_in = 1'b1;
    for (int i = 0; i < 85; i++) begin
      if (i == 3) sig_in = 1'b0;
      cyc();
      if (state_dbg == MEAS && meas_at < 0) meas_at = i;
      if (timeout) begin
        to_at = i;
        to_state = state_dbg;
      end
    end
    chk("to_pulses", tcnt, 1);
    chk("to_delay", to_at - meas_at, 50);
    chk("to_state_at_pulse", 32'(to_state), 32'(ARM));
    chk("to_no_valid", vcnt, 0);
    chk("to_end_state", 32'(state_dbg), 32'(ARM));

    // Rise on the MAX_CNT cycle wins over timeout
    restart();
    ready = 1'b1;
    wave(50, 5, 2);
    exp_q.push_back(pk(50, 5));
    score("max");
    chk("max_no_timeout", tcnt, 0);

    // Reset mid-period
    restart();
    wave(10, 4, 3);
    sig_in = 1'b1;
    repeat (4) cyc();
    sig_in = 1'b0;
    repeat (2) cyc();
    chk("mr_pre_ovr", overrun, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("mr_valid", valid, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_period", period, 0);
    chk("mr_state", 32'(state_dbg), 32'(IDLE));
    ready = 1'b1;
    got_q.delete();
    tcnt = 0;
    repeat (4) cyc();
    wave(10, 3, 3);
    repeat (2) exp_q.push_back(pk(10, 3));
    score("mr");
    chk("mr_timeouts", tcnt, 0);

    // en=0 for one cycle mid-period
    restart();
    wave(10, 4, 3);
    sig_in = 1'b1;
    repeat (4) cyc();
    sig_in = 1'b0;
    repeat (2) cyc();
    chk("me_pre_ovr", overrun, 1);
    en = 1'b0;
    cyc();
    en = 1'b1;
    chk("me_valid", valid, 0);
    chk("me_ovr", overrun, 0);
    chk("me_state", 32'(state_dbg), 32'(IDLE));
    ready = 1'b1;
    got_q.delete();
    repeat (4) cyc();
    wave(10, 7, 3);
    repeat (2) exp_q.push_back(pk(10, 7));
    score("me");

    // Duty sweep 1..9 of period 10
    restart();
    ready = 1'b1;
    for (int h = 1; h <= 9; h++) begin
      wave(10, h, 1);
      exp_q.push_back(pk(10, h));
    end
    wave(10, 1, 1);
    score("duty");
    chk("duty_timeouts", tcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_blink_monitor

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the period and high-time counters.
REQ-002 SHALL have parameter MAX_CNT, default 2**CNT_W-1, the count at which a measurement is abandoned (timeout).
REQ-003 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  measurement enable.
REQ-006 SHALL have port sig_in  input  1  asynchronous toggling signal under test (e.g. an LED drive).
REQ-007 SHALL have port period  output  CNT_W  clk cycles between consecutive rising edges of sig_in.
REQ-008 SHALL have port high_time  output  CNT_W  clk cycles sig_in was high within that period.
REQ-009 SHALL have port valid  output  1  period/high_time hold a result.
REQ-010 SHALL have port ready  input  1  consumer accepts the result.
REQ-011 SHALL have port overrun  output  1  sticky flag: an unaccepted result was overwritten.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a measurement is abandoned.

Function
REQ-013 SHALL pass sig_in through a 2-flop synchronizer plus one history flop; rise = s1 & !s2, fall = !s1 & s2. The same latency applies to both edges, so it cancels out of measurements.
REQ-014 SHALL implement states IDLE, ARM, MEAS; en=0 forces IDLE from any state in the next cycle.
REQ-015 IDLE: counters held at 0; transition to ARM when en=1.
REQ-016 ARM: wait for rise; on rise, cnt<=1, hcnt<=1, go to MEAS. A fall seen in ARM is ignored.
REQ-017 MEAS: cnt increments by 1 each cycle; hcnt increments while s1=1 until fall, then freezes.
REQ-018 MEAS on rise: load period<=cnt, high_time<=hcnt, set valid; restart cnt<=1, hcnt<=1; stay in MEAS. Back-to-back periods SHALL be measured without a gap.
REQ-019 MEAS when cnt==MAX_CNT and no rise in that cycle: pulse timeout for 1 cycle, go to ARM, produce no result. Counters SHALL never wrap.
REQ-020 If rise and cnt==MAX_CNT occur in the same cycle, the rise wins: a result is produced and no timeout occurs.
REQ-021 Handshake: the result transfers on a cycle with valid&ready; valid clears the next cycle unless a new result loads that same cycle, in which case valid stays 1 with the new data.
REQ-022 While valid=1 and ready=0, period/high_time SHALL stay stable until a new result arrives. A new result then overwrites the held data and sets overrun.
REQ-023 overrun SHALL clear only on reset or en=0.
REQ-024 Leaving MEAS because of en=0 SHALL discard the partial measurement; valid clears in the same transition.
REQ-025 Result latency: valid asserts the cycle after the detected rise that ends the period.

Reset
REQ-026 On rst=0 at a clk edge:
- state=IDLE
- period=0, high_time=0, valid=0, overrun=0, timeout=0
- counters and synchronizer flops cleared to 0
REQ-027 Reset mid-measurement SHALL abandon the measurement with no result and no timeout pulse.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE/ARM/MEAS) and the default CNT_W constant.
REQ-029 Synchronizer + edge detector SHALL be sub-module edge_sync (outputs level, rise, fall), reusable by other input monitors.
REQ-030 Top-level FSM, counters and output register SHALL stay in blink_monitor.

Verification
REQ-031 en=1, ready=1, sig_in square wave period 10 clk, high 4 clk -> from second rise on, every result period=10, high_time=4, valid one cycle per period.
REQ-032 ready=0 across three rises at period 10 -> valid stays 1, data stable between rises, overrun=1 after second result; ready=1 then gives a single transfer; overrun stays 1 until en=0.
REQ-033 MAX_CNT=50, sig_in held low after one rise -> timeout pulses exactly once, 50 cycles after MEAS entry; valid never asserts; state returns to ARM.
REQ-034 Rise coinciding with cnt==MAX_CNT -> period=MAX_CNT, valid=1, no timeout pulse.
REQ-035 rst=0 (and separately en=0) for one cycle mid-period -> valid=0, overrun=0; next result only after two further rises, with correct values.
REQ-036 sig_in glitch-free duty sweep (high 1..9 of period 10) -> high_time matches each duty exactly; period=10 throughout.
